avm_hram_burst_tester: RTL and testbench
========================================

Name: avm_hram_burst_tester

Overview:
- Avalon-MM burst master that drives the Avalon slave port of the HyperRAM converter from the initiator side.
- On each start it writes a burst of LFSR-generated 16-bit words, then reads the same burst back and compares every returned word.
- Reports pass/fail, the mismatch count and the first failing beat. It is the self-test engine for the HyperRAM system.

Parameters:
- ADDR_W, 32, Avalon address width.
- DATA_W, 16, data width. Fixed at 16 because the LFSR is 16 bits.
- BURST_W, 11, burstcount width. Maximum burst is 2^(BURST_W-1) = 1024.
- TIMEOUT, 4096, cycles allowed with no readdatavalid before the run aborts.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- base_address  in  ADDR_W  start address, captured on start.
- burst_len  in  BURST_W  number of beats, captured on start.
- seed  in  16  LFSR seed, captured on start; 0 is replaced by 0xACE1.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  valid from done until the next start.
- timeout  out  1  sticky until the next start.
- error_count  out  BURST_W  number of mismatching beats.
- first_err_idx  out  BURST_W  beat index of the first mismatch.
- avm_address  out  ADDR_W  Avalon master address.
- avm_burstcount  out  BURST_W  Avalon master burstcount.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  16  Avalon write data.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  16  Avalon read data.
- avm_readdatavalid  in  1  Avalon read data valid.
- avm_waitrequest  in  1  Avalon waitrequest.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; state IDLE; counters cleared.
- LFSR: Galois, right shift. next = (x>>1) ^ (x[0] ? 0xB400 : 0).
  - Beat 0 uses the seed value; each later beat advances once.
  - Example for seed 0x0001: 0x0001, 0xB400, 0x5A00, 0x2D00, 0x1680.
  - Separate generator and checker LFSR registers. Both reload from the seed at the start of their phase.
- FSM states: IDLE -> WRITE -> RD_CMD -> RD_DATA -> DONE -> IDLE.
- IDLE:
  - On start with burst_len == 0: go directly to DONE with pass=0 and no bus activity.
  - On start otherwise: capture inputs, clear error_count, first_err_idx and timeout; go to WRITE.
- WRITE:
  - avm_write=1, avm_address=base_address, avm_burstcount=burst_len, avm_writedata=gen LFSR.
  - All three are held constant while avm_waitrequest=1.
  - A beat is accepted when avm_write && !avm_waitrequest. On acceptance the beat counter increments and the LFSR advances.
  - After beat burst_len-1 is accepted: deassert avm_write in the next cycle and go to RD_CMD.
  - avm_write never drops mid-burst.
- RD_CMD:
  - avm_read=1 with the same address and burstcount; hold while waitrequest=1.
  - When accepted: avm_read=0 next cycle; go to RD_DATA.
  - Exactly one read command is issued per run.
- RD_DATA:
  - Each avm_readdatavalid beat is compared with the checker LFSR, then the checker LFSR advances.
  - On mismatch: error_count increments. If this is the first mismatch, first_err_idx = beat index.
  - error_count cannot overflow, since mismatches ≤ burst_len ≤ 1024.
  - After burst_len beats received: DONE.
  - A timer counts cycles without readdatavalid and resets on each valid beat. If it reaches TIMEOUT: timeout=1, go to DONE.
  - Beats arriving after DONE are ignored.
- DONE: done=1 for one cycle; pass = (error_count == 0) && !timeout && (burst_len != 0); busy=0; return to IDLE.
- start while busy: ignored.
- readdatavalid outside RD_DATA: ignored.
- Reset mid-run: bus strobes drop immediately (asynchronous); no done pulse is issued.
- Total latency with zero waitrequest and read latency L: burst_len + 1 + L + burst_len + 1 cycles, from start to done.

Decomposition:
- Package avm_hram_pkg:
  - FSM state enum.
  - LFSR_TAPS = 16'hB400.
  - LFSR_ZERO_SEED = 16'hACE1.
  - lfsr_next function.
- One sub-module: hram_lfsr16 (load, advance, value), instantiated twice: generator and checker.

Test Plan:
- Basic run: seed 0x0001, len 4, no stalls, echo memory model.
  - Required: writedata 0x0001, 0xB400, 0x5A00, 0x2D00.
  - Required: done with pass=1 and error_count=0.
- Stall hold: waitrequest high for 3 cycles on write beat 2 and on the read command.
  - Required: address, burstcount and data held stable during each stall.
  - Required: exactly 4 beats accepted and 1 read issued; pass=1.
- Corrupted read: memory model flips bit 0 of read beat 5, len 8.
  - Required: error_count=1, first_err_idx=5, pass=0.
- Lost read data: len 16, model returns only 10 beats.
  - Required: timeout=1 at TIMEOUT cycles after the last beat; pass=0; done pulses once.
- Edge cases: burst_len 0, then seed 0 with len 1024.
  - Required for len 0: immediate done, pass=0, no avm_write or avm_read.
  - Required for seed 0: first writedata 0xACE1; 1024 beats; pass=1.
- Reset mid-run: assert reset during WRITE beat 3.
  - Required: all outputs 0 immediately.
  - Required: a subsequent start runs cleanly with pass=1.

Source files
------------

// File: rtl/avm_hram_pkg.sv
// Shared types and helpers for the HyperRAM Avalon burst self-test engine.
//   state_e        : FSM state of the burst tester
//   LFSR_TAPS      : Galois right-shift feedback mask
//   LFSR_ZERO_SEED : substitute seed, because an all-zero LFSR never leaves zero
//   lfsr_next()    : one step of the 16-bit pattern generator
package avm_hram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/hram_lfsr16.sv
// 16-bit Galois LFSR register with a synchronous seed load and step enable.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load seed_i (takes priority over advance_i)
//   seed_i        : value loaded on load_i
//   advance_i     : step the sequence once
//   value_o       : current pattern word
module hram_lfsr16
  import avm_hram_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        advance_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (advance_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/avm_hram_burst_tester.sv
// Avalon-MM burst self-test master: writes burst_len LFSR words starting at
// base_address, reads the same burst back and compares every returned beat.
// Ports:
//   clk_clk, reset_reset_n        : clock, asynchronous active-low reset
//   start, base_address,
//   burst_len, seed               : run request (sampled only while idle)
//   busy, done, pass, timeout,
//   error_count, first_err_idx    : run status and result
//   avm_*                         : Avalon-MM master port
module avm_hram_burst_tester
  import avm_hram_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 11,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_address,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [15:0]        seed,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [BURST_W-1:0] error_count,
  output logic [BURST_W-1:0] first_err_idx,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic               avm_read,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  input  logic               avm_waitrequest
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] len_q, beat_q, err_q, first_q;
  logic [15:0]        seed_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               timeout_q, pass_q;

  logic [15:0] seed_eff, gen_val, chk_val;
  logic        start_ok, wr_acc, rd_acc, rd_beat, last_beat, mismatch;
  logic        tmr_expired, pass_now, bus_active;

  assign start_ok    = (state_q == ST_IDLE) && start;
  assign seed_eff    = (seed == '0) ? LFSR_ZERO_SEED : seed;
  assign wr_acc      = (state_q == ST_WRITE) && !avm_waitrequest;
  assign rd_acc      = (state_q == ST_RD_CMD) && !avm_waitrequest;
  assign rd_beat     = (state_q == ST_RD_DATA) && avm_readdatavalid;
  assign last_beat   = (beat_q == len_q - 1'b1);
  assign mismatch    = (avm_readdata != chk_val);
  assign tmr_expired = (state_q == ST_RD_DATA) && !avm_readdatavalid && (tmr_q == TMR_LAST);
  assign pass_now    = (err_q == '0) && !timeout_q && (len_q != '0);

  hram_lfsr16 u_gen (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .load_i    (start_ok),
    .seed_i    (seed_eff),
    .advance_i (wr_acc),
    .value_o   (gen_val)
  );

  // Checker reloads for every cycle spent in RD_CMD so it holds the seed when
  // the first read beat can arrive.
  hram_lfsr16 u_chk (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .load_i    (state_q == ST_RD_CMD),
    .seed_i    (seed_q),
    .advance_i (rd_beat),
    .value_o   (chk_val)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = (burst_len == '0) ? ST_DONE : ST_WRITE;
      ST_WRITE:   if (wr_acc && last_beat) state_d = ST_RD_CMD;
      ST_RD_CMD:  if (rd_acc) state_d = ST_RD_DATA;
      ST_RD_DATA: if ((rd_beat && last_beat) || tmr_expired) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      tmr_q     <= '0;
      timeout_q <= '0;
      pass_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= base_address;
            len_q     <= burst_len;
            seed_q    <= seed_eff;
            beat_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
            tmr_q     <= '0;
            timeout_q <= '0;
            pass_q    <= '0;
          end
        end
        ST_WRITE: begin
          if (wr_acc) beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
        ST_RD_CMD: begin
          tmr_q <= '0;
        end
        ST_RD_DATA: begin
          if (rd_beat) begin
            beat_q <= beat_q + 1'b1;
            tmr_q  <= '0;
            if (mismatch) begin
              err_q <= err_q + 1'b1;
              if (err_q == '0) first_q <= beat_q;
            end
          end else if (tmr_q == TMR_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_DONE: begin
          pass_q <= pass_now;
        end
        default: ;
      endcase
    end
  end

  // Bus and status outputs decode from registered state so an asynchronous
  // reset clears them at once.
  assign avm_write      = (state_q == ST_WRITE);
  assign avm_read       = (state_q == ST_RD_CMD);
  assign bus_active     = avm_write || avm_read;
  assign avm_address    = bus_active ? addr_q : '0;
  assign avm_burstcount = bus_active ? len_q : '0;
  assign avm_writedata  = avm_write ? gen_val : '0;
  assign busy           = (state_q == ST_WRITE) || (state_q == ST_RD_CMD) || (state_q == ST_RD_DATA);
  assign done           = (state_q == ST_DONE);
  assign pass           = done ? pass_now : pass_q;
  assign timeout        = timeout_q;
  assign error_count    = err_q;
  assign first_err_idx  = first_q;

endmodule

// File: tb/tb_avm_hram_burst_tester.sv
module tb_avm_hram_burst_tester;
  localparam int ADDR_W = 32, BURST_W = 11, TIMEOUT = 4096;

  logic               clk_clk = 1'b0, reset_reset_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0]  base_address = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [15:0]        seed = '0;
  logic               busy, done, pass, timeout;
  logic [BURST_W-1:0] error_count, first_err_idx, avm_burstcount;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_write, avm_read;
  logic [15:0]        avm_writedata;
  logic [15:0]        avm_readdata = '0;
  logic               avm_readdatavalid = 1'b0, avm_waitrequest = 1'b0;

  avm_hram_burst_tester #(.ADDR_W(ADDR_W), .DATA_W(16), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .base_address(base_address), .burst_len(burst_len), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_err_idx(first_err_idx),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk_clk = ~clk_clk;

  int unsigned cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Slave behaviour for the current run, owned by the stimulus process.
  int          st_wr_beat, st_wr_n, st_rd_n, rd_lat, ret_beats;
  bit          rand_wait, rand_gap;
  logic [15:0] xmask [1024];

  typedef struct {bit pass; int err; int first; bit tmo; int nwr; int nrd;} res_t;
  res_t               exp_res[$];
  logic [15:0]        exp_wr[$];
  logic [ADDR_W-1:0]  exp_addr;
  logic [BURST_W-1:0] exp_len;
  int unsigned        last_valid_cyc = 0;

  // Echo memory slave: stores written beats by index and replays them on read.
  initial begin
    int wbeat, wr_st, rd_st, rd_idx, rd_wait;
    logic [15:0] mem [1024];
    logic [15:0] rdq[$];
    wbeat = 0; wr_st = 0; rd_st = 0; rd_idx = 0; rd_wait = 0;
    forever begin
      @(posedge clk_clk); #1;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      if (avm_write && wbeat == st_wr_beat && wr_st < st_wr_n) begin
        avm_waitrequest = 1'b1; wr_st++;
      end else if (avm_read && rd_st < st_rd_n) begin
        avm_waitrequest = 1'b1; rd_st++;
      end else if ((avm_write || avm_read) && rand_wait && $urandom_range(2) == 0) begin
        avm_waitrequest = 1'b1;
      end
      if (rd_wait > 0) rd_wait--;
      else if (rdq.size() > 0 && !(rand_gap && $urandom_range(3) == 0)) begin
        if (rd_idx < ret_beats) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rdq.pop_front() ^ xmask[rd_idx];
          last_valid_cyc = cyc;
          rd_idx++;
        end else rdq.delete();
      end
      @(negedge clk_clk);
      if (!reset_reset_n || start) begin
        wbeat = 0; wr_st = 0; rd_st = 0; rd_idx = 0; rd_wait = 0; rdq.delete();
      end else begin
        if (avm_write && !avm_waitrequest && wbeat < 1024) begin
          mem[wbeat] = avm_writedata; wbeat++;
        end
        if (avm_read && !avm_waitrequest) begin
          for (int i = 0; i < int'(avm_burstcount); i++) rdq.push_back(mem[i]);
          rd_wait = rd_lat;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a result.
  initial begin
    int nwr, nrd;
    logic prev_stall;
    logic [63:0] prev_vec;
    res_t r;
    nwr = 0; nrd = 0; prev_stall = 1'b0; prev_vec = '0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        prev_stall = 1'b0; nwr = 0; nrd = 0;
        continue;
      end
      if (start) begin nwr = 0; nrd = 0; end
      if (prev_stall)
        chk("stall_hold", {avm_write, avm_read, avm_address, avm_burstcount, avm_writedata}, prev_vec);
      prev_vec   = {avm_write, avm_read, avm_address, avm_burstcount, avm_writedata};
      prev_stall = (avm_write || avm_read) && avm_waitrequest;
      if (avm_write && !avm_waitrequest) begin
        nwr++;
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_data", avm_writedata, exp_wr.pop_front());
        chk("wr_addr_bc", {avm_address, avm_burstcount}, {exp_addr, exp_len});
      end
      if (avm_read && !avm_waitrequest) begin
        nrd++;
        chk("rd_addr_bc", {avm_address, avm_burstcount}, {exp_addr, exp_len});
      end
      if (done) begin
        if (exp_res.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          r = exp_res.pop_front();
          chk("pass", pass, r.pass);
          chk("error_count", error_count, r.err);
          chk("first_err_idx", first_err_idx, r.first);
          chk("timeout", timeout, r.tmo);
          chk("write_beats", nwr, r.nwr);
          chk("read_cmds", nrd, r.nrd);
          if (r.tmo) chk("timeout_delay", (cyc - last_valid_cyc) inside {[TIMEOUT:TIMEOUT+2]}, 1);
        end
      end
    end
  end

  task automatic cfg_clear();
    st_wr_beat = -1; st_wr_n = 0; st_rd_n = 0; rd_lat = 2; ret_beats = 2000;
    rand_wait = 0; rand_gap = 0;
    foreach (xmask[i]) xmask[i] = '0;
  endtask

  // Expected results come from the plain sequence rule and the slave config.
  task automatic issue(input logic [15:0] sd, input int len, input logic [ADDR_W-1:0] ad);
    res_t r;
    logic [15:0] x;
    int n;
    @(posedge clk_clk); #1;
    x = (sd == 16'h0) ? 16'hACE1 : sd;
    exp_addr = ad;
    exp_len  = BURST_W'(len);
    for (int i = 0; i < len; i++) begin
      exp_wr.push_back(x);
      x = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    end
    n = (ret_beats < len) ? ret_beats : len;
    r.err = 0; r.first = 0;
    for (int i = 0; i < n; i++)
      if (xmask[i] != 16'h0) begin
        if (r.err == 0) r.first = i;
        r.err++;
      end
    r.tmo  = (ret_beats < len);
    r.pass = (len != 0) && !r.tmo && (r.err == 0);
    r.nwr  = len;
    r.nrd  = (len != 0) ? 1 : 0;
    exp_res.push_back(r);
    base_address = ad; burst_len = BURST_W'(len); seed = sd; start = 1'b1;
    @(posedge clk_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int len);
    int k;
    k = 0;
    do begin
      @(negedge clk_clk); k++;
    end while (!done && k < 4 * len + TIMEOUT + 200);
    if (!done) begin
      chk("done_within_budget", 0, 1);
      exp_wr.delete(); exp_res.delete();
    end
    repeat (3) @(negedge clk_clk);
  endtask

  task automatic run(input logic [15:0] sd, input int len, input logic [ADDR_W-1:0] ad);
    issue(sd, len, ad);
    wait_done(len);
  endtask

  initial begin
    int k, len;
    cfg_clear();
    #12;
    chk("reset_ctrl", {busy, done, pass, timeout, error_count, first_err_idx, avm_write, avm_read}, 0);
    chk("reset_bus", {avm_address, avm_burstcount, avm_writedata}, 0);
    @(negedge clk_clk); reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    // basic run
    run(16'h0001, 4, 32'h0000_1000);
    // stall on write beat 2 and on the read command
    cfg_clear(); st_wr_beat = 2; st_wr_n = 3; st_rd_n = 3;
    run(16'h0001, 4, 32'h0000_2000);
    // corrupted read beat 5
    cfg_clear(); xmask[5] = 16'h0001;
    run(16'hBEEF, 8, 32'h0000_3000);
    // lost read data
    cfg_clear(); ret_beats = 10;
    run(16'h1357, 16, 32'h0000_4000);
    // zero length
    cfg_clear();
    run(16'h2222, 0, 32'h0000_5000);
    // zero seed, maximum burst
    cfg_clear(); rd_lat = 1;
    run(16'h0000, 1024, 32'h0001_0000);

    // reset during write beat 3
    cfg_clear();
    issue(16'h4321, 8, 32'h0000_6000);
    k = 0;
    do begin @(negedge clk_clk); k++; end while (!avm_write && k < 20);
    repeat (3) @(negedge clk_clk);
    chk("pre_reset_write", {busy, avm_write}, 2'b11);
    #1 reset_reset_n = 1'b0;
    #1;
    chk("midrun_reset_ctrl", {busy, done, pass, timeout, error_count, first_err_idx, avm_write, avm_read}, 0);
    chk("midrun_reset_bus", {avm_address, avm_burstcount, avm_writedata}, 0);
    exp_wr.delete(); exp_res.delete();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    run(16'h4321, 8, 32'h0000_6000);

    // randomized runs
    for (int t = 0; t < 12; t++) begin
      cfg_clear();
      rand_wait = 1'($urandom_range(1));
      rand_gap  = 1'($urandom_range(1));
      rd_lat    = int'($urandom_range(0, 6));
      len       = int'($urandom_range(1, 48));
      for (int i = 0; i < len; i++)
        if ($urandom_range(5) == 0) xmask[i] = 16'($urandom_range(1, 65535));
      run(16'($urandom), len, ADDR_W'($urandom));
    end

    chk("leftover_expectations", exp_wr.size() + exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
